noc_toggle_bridge: RTL

- Sits between the Wishbone slave interface and one NoC wrapper, and sequences the toggle-signalled mailbox.
- Converts each noc_rx_toggle flip into a push of {noc_rx_bits, noc_rx} into an RX FIFO, drained by the NoC wrapper through valid/ready.
- Buffers NoC-to-host words in a TX FIFO and presents the head on noc_tx with a valid flag. A noc_tx_toggle flip pops the word the host just read.
- Provides sticky overflow/underflow status and occupancy counts.

---
 rtl/noc_bridge_pkg.sv | 17 +
 rtl/noc_sync_fifo.sv | 69 ++++++
 rtl/noc_toggle_bridge.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/noc_bridge_pkg.sv
// Shared constants and helpers for the NoC toggle-mailbox bridge.
package noc_bridge_pkg;

    localparam logic [31:0] NOC_RX_ADDR = 32'hFFFF0000;
    localparam logic [31:0] NOC_TX_ADDR = 32'hFFFF0004;

    // Bit of noc_tx that carries the "TX FIFO non-empty" flag.
    function automatic int tx_flag_bit(input int noc_wid);
        return noc_wid - 1;
    endfunction

    // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with combinational head, separate occupancy counter and flush.
module noc_sync_fifo
    import noc_bridge_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          flush,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_CNT);

    // A pop frees the slot in the same cycle, so push-while-full succeeds alongside it.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + CW'(1);
        end else if (do_pop && !do_push) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    assign dout  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/noc_toggle_bridge.sv
// Toggle-signalled mailbox between the Wishbone host side and one NoC wrapper,
// with RX/TX FIFOs, sticky error flags and occupancy counts.
module noc_toggle_bridge
    import noc_bridge_pkg::*;
#(
    parameter int NOC_WID = 16,
    parameter int DEPTH   = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          en,
    input  logic [NOC_WID-1:0]            noc_rx,
    input  logic [7:0]                    noc_rx_bits,
    input  logic                          noc_rx_toggle,
    output logic [NOC_WID-1:0]            noc_tx,
    input  logic                          noc_tx_toggle,
    output logic                          rx_valid,
    output logic [NOC_WID-1:0]            rx_data,
    output logic [7:0]                    rx_bits,
    input  logic                          rx_ready,
    input  logic                          tx_valid,
    input  logic [NOC_WID-2:0]            tx_data,
    output logic                          tx_ready,
    input  logic                          status_clr,
    output logic                          rx_overflow,
    output logic                          tx_underflow,
    output logic [count_width(DEPTH)-1:0] rx_count,
    output logic [count_width(DEPTH)-1:0] tx_count
);

    localparam int FLAG_BIT = tx_flag_bit(NOC_WID);

    logic                 rx_tog_reg;
    logic                 tx_tog_reg;
    logic                 tx_vld_reg;
    logic                 rx_overflow_reg;
    logic                 rx_overflow_next;
    logic                 tx_underflow_reg;
    logic                 tx_underflow_next;

    logic                 rx_edge;
    logic                 tx_edge;
    logic                 rx_push;
    logic                 rx_pop;
    logic                 rx_full;
    logic                 rx_empty;
    logic                 tx_push;
    logic                 tx_pop;
    logic                 tx_full;
    logic                 tx_empty;
    logic                 ovf_evt;
    logic                 unf_evt;
    logic [NOC_WID+7:0]   rx_head;
    logic [NOC_WID-2:0]   tx_head;
    logic [NOC_WID-2:0]   tx_payload;

    assign rx_edge = noc_rx_toggle ^ rx_tog_reg;
    assign tx_edge = noc_tx_toggle ^ tx_tog_reg;

    assign rx_valid = ~rx_empty;
    assign rx_pop   = en & rx_valid & rx_ready;
    assign rx_push  = en & rx_edge;
    assign ovf_evt  = en & rx_edge & rx_full & ~rx_pop;

    assign tx_ready = en & ~tx_full;
    assign tx_push  = tx_valid & tx_ready;
    // Only pop if the host actually saw a valid word on its read cycle; a word
    // pushed after it sampled an empty FIFO must survive for the next read.
    assign tx_pop   = en & tx_edge & tx_vld_reg;
    assign unf_evt  = en & tx_edge & ~tx_vld_reg;

    noc_sync_fifo #(
        .WIDTH (NOC_WID + 8),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .flush    (~en),
        .push     (rx_push),
        .pop      (rx_pop),
        .din      ({noc_rx_bits, noc_rx}),
        .dout     (rx_head),
        .full     (rx_full),
        .empty    (rx_empty),
        .count    (rx_count)
    );

    noc_sync_fifo #(
        .WIDTH (NOC_WID - 1),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .flush    (~en),
        .push     (tx_push),
        .pop      (tx_pop),
        .din      (tx_data),
        .dout     (tx_head),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (tx_count)
    );

    assign rx_data = rx_head[NOC_WID-1:0];
    assign rx_bits = rx_head[NOC_WID+7:NOC_WID];

    for (genvar gi = 0; gi < NOC_WID - 1; gi++) begin : g_tx_mask
        assign tx_payload[gi] = tx_head[gi] & ~tx_empty;
    end

    assign noc_tx = {~tx_empty, tx_payload};

    // A set event in the same cycle as status_clr wins over the clear.
    always_comb begin
        rx_overflow_next  = rx_overflow_reg;
        tx_underflow_next = tx_underflow_reg;
        if (status_clr) begin
            rx_overflow_next  = 1'b0;
            tx_underflow_next = 1'b0;
        end
        if (ovf_evt) rx_overflow_next  = 1'b1;
        if (unf_evt) tx_underflow_next = 1'b1;
    end

    // Toggle trackers follow their inputs even in reset, so no edge appears afterwards.
    always_ff @(posedge wb_clk_i) begin
        rx_tog_reg <= noc_rx_toggle;
        tx_tog_reg <= noc_tx_toggle;
        if (wb_rst_i) begin
            tx_vld_reg       <= 1'b0;
            rx_overflow_reg  <= 1'b0;
            tx_underflow_reg <= 1'b0;
        end else begin
            tx_vld_reg       <= noc_tx[FLAG_BIT];
            rx_overflow_reg  <= rx_overflow_next;
            tx_underflow_reg <= tx_underflow_next;
        end
    end

    assign rx_overflow  = rx_overflow_reg;
    assign tx_underflow = tx_underflow_reg;

endmodule
